qea_state_readout: RTL

Post-processing stage downstream of the QEA core. After the core signals completion, it sweeps the core's state RAM through the external state port and squares every complex amplitude into a probability. It accumulates one Pauli-Z expectation value per qubit, which is the per-patch feature for quanvolutional circuits. Results are streamed out one qubit per beat over a valid/ready handshake.

---
 rtl/qea_readout_pkg.sv | 38 +++
 rtl/qea_state_readout_if.sv | 29 ++
 rtl/qea_amp_sq.sv | 28 ++
 rtl/qea_state_readout.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qea_readout_pkg.sv
// Shared types, sizes and helpers for the QEA state readout stage.
package qea_readout_pkg;

    localparam int unsigned PE_NUM_WIDTH     = 2;
    localparam int unsigned PE_NUM           = 4;
    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned STATE_DATA_WIDTH = 64;
    localparam int unsigned STATE_ADDR_WIDTH = 16;
    localparam int unsigned MAX_QBIT_WIDTH   = 6;
    localparam int unsigned MAX_QBIT         = 16;
    localparam int unsigned NUM_FRAC_BIT     = 30;
    localparam int unsigned ACC_WIDTH        = 40;
    localparam int unsigned RD_LATENCY       = 1;

    localparam logic signed [ACC_WIDTH-1:0] ONE = ACC_WIDTH'(1) <<< NUM_FRAC_BIT;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        EMIT
    } state_e;

    // Field order matches the lane word layout {real, imag}
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } amp_t;

    function automatic amp_t lane_amp(input logic [PE_NUM*STATE_DATA_WIDTH-1:0] word,
                                      input int unsigned lane);
        amp_t a;
        a.re = word[lane*STATE_DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
        a.im = word[lane*STATE_DATA_WIDTH +: DATA_WIDTH];
        return a;
    endfunction

endpackage

// File: rtl/qea_state_readout_if.sv
// Start/state-port/result-stream bundle of the readout stage; master is the readout block.
interface qea_state_readout_if;
    import qea_readout_pkg::*;

    logic                               start;
    logic [MAX_QBIT_WIDTH-1:0]          qbit_num;
    logic [PE_NUM-1:0]                  state_ena;
    logic [PE_NUM-1:0]                  state_wea;
    logic [STATE_ADDR_WIDTH-1:0]        state_addra;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0] state_dout;
    logic                               valid;
    logic                               ready;
    logic [MAX_QBIT_WIDTH-1:0]          qbit_idx;
    logic [ACC_WIDTH-1:0]               expval;
    logic [ACC_WIDTH-1:0]               norm;
    logic                               busy;
    logic                               done;
    logic                               error;

    modport master (
        input  start, qbit_num, state_dout, ready,
        output state_ena, state_wea, state_addra, valid, qbit_idx, expval, norm, busy, done, error
    );

    modport slave (
        output start, qbit_num, state_dout, ready,
        input  state_ena, state_wea, state_addra, valid, qbit_idx, expval, norm, busy, done, error
    );
endinterface

// File: rtl/qea_amp_sq.sv
// Single-lane |amp|^2 in Q(NUM_FRAC_BIT), one register stage, floor rounding.
module qea_amp_sq
    import qea_readout_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  amp_t                        amp,
    output logic signed [ACC_WIDTH-1:0] prob
);
    localparam int unsigned PROD_WIDTH = 2*DATA_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0] re_x;
    logic signed [PROD_WIDTH-1:0] im_x;
    logic signed [PROD_WIDTH-1:0] mag_sq;
    logic signed [ACC_WIDTH-1:0]  prob_d;

    always_comb begin
        re_x   = PROD_WIDTH'(amp.re);
        im_x   = PROD_WIDTH'(amp.im);
        mag_sq = re_x * re_x + im_x * im_x;
        prob_d = ACC_WIDTH'(mag_sq >>> NUM_FRAC_BIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prob <= '0;
        else     prob <= prob_d;
    end
endmodule

// File: rtl/qea_state_readout.sv
// Sweeps the QEA state RAM, squares amplitudes and streams one <Z_q> per qubit.
// Define QEA_READOUT_NORM_EN to build the total-probability accumulator driving norm.
module qea_state_readout
    import qea_readout_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    qea_state_readout_if.master bus
);
    localparam int unsigned QIDX_WIDTH  = $clog2(MAX_QBIT);
    localparam int unsigned DRAIN_WIDTH = 4;
    localparam int unsigned DRAIN_LAST  = RD_LATENCY + 1;

    state_e                          state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]       n_q, n_d;
    logic [MAX_QBIT_WIDTH-1:0]       shift;
    logic [STATE_ADDR_WIDTH-1:0]     addr_q, addr_d, last_addr;
    logic [PE_NUM-1:0]               ena_q, ena_d;
    logic [DRAIN_WIDTH-1:0]          drain_q, drain_d;
    logic                            valid_q, valid_d;
    logic [MAX_QBIT_WIDTH-1:0]       idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]     expval_q, expval_d;
    logic signed [ACC_WIDTH-1:0]     norm_q, norm_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            error_q, error_d;
    logic                            legal_n;
    logic                            launch;

    logic [RD_LATENCY-1:0]           rd_vld;
    logic [STATE_ADDR_WIDTH-1:0]     rd_addr [RD_LATENCY];
    logic                            sq_vld;
    logic [STATE_ADDR_WIDTH-1:0]     sq_addr;
    logic signed [ACC_WIDTH-1:0]     prob  [PE_NUM];
    logic signed [ACC_WIDTH-1:0]     acc   [MAX_QBIT];
    logic signed [ACC_WIDTH-1:0]     delta [MAX_QBIT];

    assign shift     = n_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    assign last_addr = STATE_ADDR_WIDTH'((32'd1 << shift) - 32'd1);
    assign legal_n   = (bus.qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) &&
                       (bus.qbit_num <= MAX_QBIT_WIDTH'(MAX_QBIT));

    // Read-data alignment: address/valid ride alongside the RAM latency, then the square stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld  <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) rd_addr[i] <= '0;
            sq_vld  <= 1'b0;
            sq_addr <= '0;
        end else begin
            rd_vld[0]  <= ena_q[0];
            rd_addr[0] <= addr_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_vld[i]  <= rd_vld[i-1];
                rd_addr[i] <= rd_addr[i-1];
            end
            sq_vld  <= rd_vld[RD_LATENCY-1];
            sq_addr <= rd_addr[RD_LATENCY-1];
        end
    end

    for (genvar p = 0; p < PE_NUM; p++) begin : g_lane
        amp_t lane_in;
        assign lane_in = lane_amp(bus.state_dout, p);
        qea_amp_sq u_amp_sq (
            .clk  (clk),
            .rst  (rst),
            .amp  (lane_in),
            .prob (prob[p])
        );
    end

    // Lane index supplies the basis MSBs above the sweep address
    always_comb begin
        logic [MAX_QBIT-1:0] basis;
        basis = '0;
        for (int unsigned q = 0; q < MAX_QBIT; q++) delta[q] = '0;
        for (int unsigned p = 0; p < PE_NUM; p++) begin
            basis = MAX_QBIT'(sq_addr) | (MAX_QBIT'(p) << shift);
            for (int unsigned q = 0; q < MAX_QBIT; q++)
                delta[q] = basis[q] ? delta[q] - prob[p] : delta[q] + prob[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned q = 0; q < MAX_QBIT; q++) acc[q] <= '0;
        end else if (launch) begin
            for (int unsigned q = 0; q < MAX_QBIT; q++) acc[q] <= '0;
        end else if (sq_vld) begin
            for (int unsigned q = 0; q < MAX_QBIT; q++) acc[q] <= acc[q] + delta[q];
        end
    end

`ifdef QEA_READOUT_NORM_EN
    logic signed [ACC_WIDTH-1:0] norm_acc;
    logic signed [ACC_WIDTH-1:0] norm_delta;

    always_comb begin
        norm_delta = '0;
        for (int unsigned p = 0; p < PE_NUM; p++) norm_delta = norm_delta + prob[p];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         norm_acc <= '0;
        else if (launch) norm_acc <= '0;
        else if (sq_vld) norm_acc <= norm_acc + norm_delta;
    end
`endif

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        addr_d   = addr_q;
        ena_d    = '0;
        drain_d  = '0;
        valid_d  = valid_q;
        idx_d    = idx_q;
        expval_d = expval_q;
        norm_d   = norm_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        launch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (legal_n) begin
                        state_d = SWEEP;
                        n_d     = bus.qbit_num;
                        addr_d  = '0;
                        ena_d   = '1;
                        norm_d  = '0;
                        launch  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            SWEEP: begin
                if (addr_q == last_addr) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + STATE_ADDR_WIDTH'(1);
                    ena_d  = '1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_WIDTH'(DRAIN_LAST)) begin
                    state_d  = EMIT;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    expval_d = acc[0];
`ifdef QEA_READOUT_NORM_EN
                    norm_d   = norm_acc;
`endif
                end else begin
                    drain_d = drain_q + DRAIN_WIDTH'(1);
                end
            end
            EMIT: begin
                if (valid_q && bus.ready) begin
                    if (idx_q == n_q - MAX_QBIT_WIDTH'(1)) begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        idx_d    = '0;
                        expval_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d    = idx_q + MAX_QBIT_WIDTH'(1);
                        expval_d = acc[idx_d[QIDX_WIDTH-1:0]];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            addr_q   <= '0;
            ena_q    <= '0;
            drain_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            expval_q <= '0;
            norm_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
            ena_q    <= ena_d;
            drain_q  <= drain_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            expval_q <= expval_d;
            norm_q   <= norm_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.state_ena   = ena_q;
    assign bus.state_wea   = '0;
    assign bus.state_addra = addr_q;
    assign bus.valid       = valid_q;
    assign bus.qbit_idx    = idx_q;
    assign bus.expval      = expval_q;
    assign bus.norm        = norm_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
endmodule
